uart_reg_bridge: RTL

Host-side command responder that sits on the far side of the UART's buffered byte interface. It pops command bytes from the receive FIFO port and executes single-register reads and writes on a simple register bus. It then pushes one response byte into the transmit FIFO port. This lets a PC terminal peek and poke on-chip control registers over the serial link.

---
 rtl/uart_reg_bridge.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_reg_bridge.sv
// Serial command responder: pops 'W'/'R' frames from the RX FIFO, performs one
// register bus access and pushes a single response byte into the TX FIFO.
module uart_reg_bridge #(
    parameter int FRAME_WIDTH = 8,
    parameter int TIMEOUT     = 100000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [FRAME_WIDTH-1:0] r_data,
    input  logic                   rx_empty,
    output logic                   rd_uart,
    output logic [FRAME_WIDTH-1:0] w_data,
    input  logic                   tx_full,
    output logic                   wr_uart,
    output logic [FRAME_WIDTH-1:0] reg_addr,
    output logic [FRAME_WIDTH-1:0] reg_wdata,
    output logic                   reg_we,
    output logic                   reg_re,
    input  logic [FRAME_WIDTH-1:0] reg_rdata,
    output logic                   busy,
    output logic                   err_timeout
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] GET_ADDR = 3'd1;
    localparam logic [2:0] GET_DATA = 3'd2;
    localparam logic [2:0] BUS_WR   = 3'd3;
    localparam logic [2:0] BUS_RD   = 3'd4;
    localparam logic [2:0] RD_WAIT  = 3'd5;
    localparam logic [2:0] SEND     = 3'd6;

    localparam logic [FRAME_WIDTH-1:0] OP_W   = FRAME_WIDTH'(8'h57);
    localparam logic [FRAME_WIDTH-1:0] OP_R   = FRAME_WIDTH'(8'h52);
    localparam logic [FRAME_WIDTH-1:0] RSP_OK = FRAME_WIDTH'(8'h4B);
    localparam logic [FRAME_WIDTH-1:0] RSP_BAD = FRAME_WIDTH'(8'h3F);

    logic [2:0]             state_r;
    logic [2:0]             state_s;
    logic                   op_wr_r;
    logic [CW-1:0]          cnt_r;
    logic [FRAME_WIDTH-1:0] resp_r;
    logic [FRAME_WIDTH-1:0] addr_r;
    logic [FRAME_WIDTH-1:0] wdata_r;
    logic                   err_r;
    logic                   in_frame_s;
    logic                   pop_s;
    logic                   timeout_s;

    assign in_frame_s = (state_r == GET_ADDR) || (state_r == GET_DATA);
    assign pop_s      = ((state_r == IDLE) || in_frame_s) && !rx_empty;
    assign timeout_s  = in_frame_s && rx_empty && (cnt_r == TO_MAX);

    assign rd_uart     = pop_s && !reset;
    assign wr_uart     = (state_r == SEND) && !tx_full && !reset;
    assign reg_we      = (state_r == BUS_WR);
    assign reg_re      = (state_r == BUS_RD);
    assign busy        = (state_r != IDLE);
    assign w_data      = resp_r;
    assign reg_addr    = addr_r;
    assign reg_wdata   = wdata_r;
    assign err_timeout = err_r;

    // Next-state decode for the frame sequencer
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!rx_empty) begin
                    if ((r_data == OP_W) || (r_data == OP_R)) begin
                        state_s = GET_ADDR;
                    end else begin
                        state_s = SEND;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            GET_ADDR: begin
                if (!rx_empty) begin
                    state_s = op_wr_r ? GET_DATA : BUS_RD;
                end else if (timeout_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = GET_ADDR;
                end
            end
            GET_DATA: begin
                if (!rx_empty) begin
                    state_s = BUS_WR;
                end else if (timeout_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = GET_DATA;
                end
            end
            BUS_WR:  state_s = SEND;
            BUS_RD:  state_s = RD_WAIT;
            RD_WAIT: state_s = SEND;
            SEND: begin
                if (!tx_full) begin
                    state_s = IDLE;
                end else begin
                    state_s = SEND;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, captured frame fields, response byte and inter-byte timer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            op_wr_r <= 1'b0;
            cnt_r   <= '0;
            resp_r  <= '0;
            addr_r  <= '0;
            wdata_r <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            err_r   <= timeout_s;
            // Timer only runs while waiting mid-frame; any pop restarts it
            if (pop_s || !in_frame_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        op_wr_r <= (r_data == OP_W);
                        if ((r_data != OP_W) && (r_data != OP_R)) begin
                            resp_r <= RSP_BAD;
                        end
                    end
                end
                GET_ADDR: begin
                    if (pop_s) begin
                        addr_r <= r_data;
                    end
                end
                GET_DATA: begin
                    if (pop_s) begin
                        wdata_r <= r_data;
                    end
                end
                BUS_WR:  resp_r <= RSP_OK;
                RD_WAIT: resp_r <= reg_rdata;
                default: ;
            endcase
        end
    end

endmodule
